// File: rtl/metaballs_pkg.sv
// Shared widths, FSM encoding and centre-point helper for the metaball motion engine.
package metaballs_pkg;

    localparam int POS_W   = 12;
    localparam int FRAC_W  = 2;
    localparam int VEL_W   = 10;
    localparam int COORD_W = 10;

    typedef enum logic [1:0] {IDLE, CALC, COMMIT, PUBLISH} state_e;

    function automatic logic [POS_W-1:0] centre_fix(input int screen, input int size);
        return POS_W'(((screen - size) / 2) << FRAC_W);
    endfunction

endpackage

// File: rtl/ball_step.sv
// One-axis motion step: advance position by velocity, then pull velocity toward the centre.
module ball_step
    import metaballs_pkg::*;
(
    input  logic [POS_W-1:0] pos,
    input  logic [VEL_W-1:0] vel,
    input  logic [POS_W-1:0] centre,
    output logic [POS_W-1:0] next_pos,
    output logic [VEL_W-1:0] next_vel
);

    logic [POS_W-1:0] vel_ext;

    always_comb begin
        vel_ext  = {{(POS_W-VEL_W){vel[VEL_W-1]}}, vel};
        next_pos = pos + vel_ext;
        // Velocity wraps on overflow; no saturation.
        next_vel = (next_pos < centre) ? vel + VEL_W'(1) : vel - VEL_W'(1);
    end

endmodule

// File: rtl/ball_motion.sv
// Frame-rate motion engine: on each v_sync rise, steps every ball serially and
// publishes the whole set of coordinates in one cycle.
module ball_motion
    import metaballs_pkg::*;
#(
    parameter int NUM_BALLS     = 2,
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_SIZE     = 128,
    parameter logic [COORD_W*NUM_BALLS-1:0] START_X_FLAT = {10'd425, 10'd224},
    parameter logic [COORD_W*NUM_BALLS-1:0] START_Y_FLAT = {10'd188, 10'd157}
) (
    input  logic                           clk_50mhz,
    input  logic                           rst_n,
    input  logic                           v_sync,
    input  logic                           run,
    output logic [COORD_W*NUM_BALLS-1:0]   ball_x_flat,
    output logic [COORD_W*NUM_BALLS-1:0]   ball_y_flat,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overrun
);

    localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [POS_W-1:0] CX = centre_fix(SCREEN_WIDTH, BALL_SIZE);
    localparam logic [POS_W-1:0] CY = centre_fix(SCREEN_HEIGHT, BALL_SIZE);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           v_sync_q;
    logic [POS_W-1:0]               pos_x_q [NUM_BALLS];
    logic [POS_W-1:0]               pos_x_d [NUM_BALLS];
    logic [POS_W-1:0]               pos_y_q [NUM_BALLS];
    logic [POS_W-1:0]               pos_y_d [NUM_BALLS];
    logic [VEL_W-1:0]               vel_x_q [NUM_BALLS];
    logic [VEL_W-1:0]               vel_x_d [NUM_BALLS];
    logic [VEL_W-1:0]               vel_y_q [NUM_BALLS];
    logic [VEL_W-1:0]               vel_y_d [NUM_BALLS];
    logic [POS_W-1:0]               nx_q, nx_d, ny_q, ny_d;
    logic [VEL_W-1:0]               nvx_q, nvx_d, nvy_q, nvy_d;
    logic [COORD_W*NUM_BALLS-1:0]   ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic                           busy_q, busy_d;
    logic                           frame_done_q, frame_done_d;
    logic                           overrun_q, overrun_d;
    logic                           frame_edge;
    logic [POS_W-1:0]               step_x_pos, step_y_pos;
    logic [VEL_W-1:0]               step_x_vel, step_y_vel;

    ball_step u_step_x (
        .pos      (pos_x_q[idx_q]),
        .vel      (vel_x_q[idx_q]),
        .centre   (CX),
        .next_pos (step_x_pos),
        .next_vel (step_x_vel)
    );

    ball_step u_step_y (
        .pos      (pos_y_q[idx_q]),
        .vel      (vel_y_q[idx_q]),
        .centre   (CY),
        .next_pos (step_y_pos),
        .next_vel (step_y_vel)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        vel_x_d      = vel_x_q;
        vel_y_d      = vel_y_q;
        nx_d         = nx_q;
        ny_d         = ny_q;
        nvx_d        = nvx_q;
        nvy_d        = nvy_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        frame_edge   = v_sync & ~v_sync_q & run;

        if (frame_edge && state_q != IDLE) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (frame_edge) begin
                    state_d = CALC;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CALC: begin
                nx_d    = step_x_pos;
                ny_d    = step_y_pos;
                nvx_d   = step_x_vel;
                nvy_d   = step_y_vel;
                state_d = COMMIT;
            end
            COMMIT: begin
                pos_x_d[idx_q] = nx_q;
                pos_y_d[idx_q] = ny_q;
                vel_x_d[idx_q] = nvx_q;
                vel_y_d[idx_q] = nvy_q;
                if (idx_q == IDX_W'(NUM_BALLS-1)) begin
                    // Publish from the post-commit array so the last ball is included.
                    state_d      = PUBLISH;
                    frame_done_d = 1'b1;
                    for (int i = 0; i < NUM_BALLS; i++) begin
                        ball_x_d[COORD_W*i +: COORD_W] = pos_x_d[i][POS_W-1:FRAC_W];
                        ball_y_d[COORD_W*i +: COORD_W] = pos_y_d[i][POS_W-1:FRAC_W];
                    end
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = CALC;
                end
            end
            PUBLISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            v_sync_q     <= 1'b1;
            nx_q         <= '0;
            ny_q         <= '0;
            nvx_q        <= '0;
            nvy_q        <= '0;
            ball_x_q     <= START_X_FLAT;
            ball_y_q     <= START_Y_FLAT;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                pos_x_q[i] <= {START_X_FLAT[COORD_W*i +: COORD_W], {FRAC_W{1'b0}}};
                pos_y_q[i] <= {START_Y_FLAT[COORD_W*i +: COORD_W], {FRAC_W{1'b0}}};
                vel_x_q[i] <= '0;
                vel_y_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            v_sync_q     <= v_sync;
            nx_q         <= nx_d;
            ny_q         <= ny_d;
            nvx_q        <= nvx_d;
            nvy_q        <= nvy_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            vel_x_q      <= vel_x_d;
            vel_y_q      <= vel_y_d;
        end
    end

    assign ball_x_flat = ball_x_q;
    assign ball_y_flat = ball_y_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: hand tables for frame timing and early frames, plus a
// randomized long run of a 3-ball instance against an arithmetic reference model.
module tb_ball_motion;

    logic        clk = 1'b0;
    logic        rst_n, v_sync, run, v_sync3, run3;
    logic [19:0] ball_x_flat, ball_y_flat;
    logic [29:0] ball_x3, ball_y3;
    logic        busy, frame_done, overrun, busy3, frame_done3, overrun3;

    localparam logic [29:0] SX3 = {10'd600, 10'd100, 10'd350};
    localparam logic [29:0] SY3 = {10'd50, 10'd400, 10'd236};

    always #10 clk = ~clk;

    ball_motion dut (
        .clk_50mhz(clk), .rst_n(rst_n), .v_sync(v_sync), .run(run),
        .ball_x_flat(ball_x_flat), .ball_y_flat(ball_y_flat),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    ball_motion #(.NUM_BALLS(3), .START_X_FLAT(SX3), .START_Y_FLAT(SY3)) dut3 (
        .clk_50mhz(clk), .rst_n(rst_n), .v_sync(v_sync3), .run(run3),
        .ball_x_flat(ball_x3), .ball_y_flat(ball_y3),
        .busy(busy3), .frame_done(frame_done3), .overrun(overrun3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer fixed-point, one entry per ball.
    int mn;
    int mpx[8], mpy[8], mvx[8], mvy[8];
    localparam int CXM = ((800 - 128) / 2) * 4;
    localparam int CYM = ((600 - 128) / 2) * 4;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_init(input int n, input logic [79:0] sx, input logic [79:0] sy);
        mn = n;
        for (int i = 0; i < n; i++) begin
            mpx[i] = int'(sx[10*i +: 10]) * 4;
            mpy[i] = int'(sy[10*i +: 10]) * 4;
            mvx[i] = 0;
            mvy[i] = 0;
        end
    endtask

    task automatic axis(inout int p, inout int v, input int c);
        int sv, nxt;
        sv  = (v >= 512) ? v - 1024 : v;
        nxt = (p + sv) & 4095;
        v   = (v + ((nxt < c) ? 1 : -1)) & 1023;
        p   = nxt;
    endtask

    task automatic model_step();
        for (int i = 0; i < mn; i++) begin
            axis(mpx[i], mvx[i], CXM);
            axis(mpy[i], mvy[i], CYM);
        end
    endtask

    function automatic logic [79:0] mout(input bit y);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < mn; i++) r[10*i +: 10] = 10'((y ? mpy[i] : mpx[i]) >> 2);
        return r;
    endfunction

    // Rising edge on v_sync during cycle E, then check busy/frame_done through E+6.
    task automatic frame2(input string tag);
        v_sync = 1'b0;
        tick();
        v_sync = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("%s busy E+%0d", tag, k), busy, 1);
            chk($sformatf("%s frame_done E+%0d", tag, k), frame_done, (k == 5));
        end
        tick();
        chk($sformatf("%s busy E+6", tag), busy, 0);
        chk($sformatf("%s frame_done E+6", tag), frame_done, 0);
    endtask

    typedef struct {
        logic [19:0] x;
        logic [19:0] y;
    } vec_t;

    vec_t tbl[4];

    task automatic frame3(input bit r, input int f);
        bit got;
        run3    = r;
        v_sync3 = 1'b0;
        tick();
        v_sync3 = 1'b1;
        got     = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            tick();
            if (frame_done3) got = 1'b1;
        end
        chk($sformatf("long f%0d done", f), got, r);
        if (r) model_step();
        chk($sformatf("long f%0d x", f), ball_x3, mout(1'b0));
        chk($sformatf("long f%0d y", f), ball_y3, mout(1'b1));
        repeat ($urandom_range(0, 2)) tick();
    endtask

    initial begin
        tbl[0] = '{x: {10'd425, 10'd224}, y: {10'd188, 10'd157}};
        tbl[1] = '{x: {10'd424, 10'd224}, y: {10'd188, 10'd157}};
        tbl[2] = '{x: {10'd424, 10'd224}, y: {10'd188, 10'd157}};
        tbl[3] = '{x: {10'd423, 10'd225}, y: {10'd189, 10'd158}};

        rst_n = 1'b0; v_sync = 1'b1; run = 1'b1; v_sync3 = 1'b1; run3 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset x", ball_x_flat, 20'({10'd425, 10'd224}));
        chk("reset y", ball_y_flat, 20'({10'd188, 10'd157}));
        chk("reset busy", busy, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset overrun", overrun, 0);
        model_init(2, 80'({10'd425, 10'd224}), 80'({10'd188, 10'd157}));

        for (int f = 0; f < 4; f++) begin
            frame2($sformatf("frame%0d", f + 1));
            model_step();
            chk($sformatf("frame%0d x", f + 1), ball_x_flat, tbl[f].x);
            chk($sformatf("frame%0d y", f + 1), ball_y_flat, tbl[f].y);
        end

        // Frozen: edges with run low must be ignored entirely.
        run = 1'b0;
        for (int e = 0; e < 5; e++) begin
            v_sync = 1'b0;
            tick();
            v_sync = 1'b1;
            for (int k = 0; k < 6; k++) begin
                tick();
                chk($sformatf("pause e%0d frame_done", e), frame_done, 0);
            end
        end
        chk("pause x", ball_x_flat, tbl[3].x);
        chk("pause y", ball_y_flat, tbl[3].y);
        chk("pause busy", busy, 0);
        chk("pause overrun", overrun, 0);
        run = 1'b1;

        // Overrun: second rising edge lands in cycle E+2.
        v_sync = 1'b0;
        tick();
        v_sync = 1'b1;
        tick();
        v_sync = 1'b0;
        tick();
        v_sync = 1'b1;
        tick();
        chk("overrun set", overrun, 1);
        chk("overrun E+3 frame_done", frame_done, 0);
        tick();
        chk("overrun E+4 frame_done", frame_done, 0);
        tick();
        chk("overrun E+5 frame_done", frame_done, 1);
        model_step();
        chk("overrun frame x", ball_x_flat, mout(1'b0));
        chk("overrun frame y", ball_y_flat, mout(1'b1));
        repeat (3) tick();
        chk("overrun sticky", overrun, 1);
        chk("overrun idle busy", busy, 0);

        // Reset during the update at E+3.
        v_sync = 1'b0;
        tick();
        v_sync = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst busy", busy, 0);
        chk("midrst overrun", overrun, 0);
        chk("midrst x", ball_x_flat, tbl[0].x);
        chk("midrst y", ball_y_flat, tbl[0].y);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("midrst frame_done %0d", k), frame_done, 0);
            tick();
        end
        frame2("after_rst");
        chk("after_rst x", ball_x_flat, tbl[0].x);
        chk("after_rst y", ball_y_flat, tbl[0].y);

        // Long randomized run on the 3-ball instance.
        model_init(3, 80'(SX3), 80'(SY3));
        chk("long reset x", ball_x3, mout(1'b0));
        for (int f = 0; f < 2000; f++) frame3($urandom_range(0, 9) != 0, f);
        chk("long overrun", overrun3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
